imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width (depth 2**ADDR_W).
REQ-002 SHALL have parameter HALT_WORD, default 16'hFFFF, meaning the end-of-program sentinel word.
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a program load.
REQ-006 SHALL have port byte_valid  input  1  source presents a byte.
REQ-007 SHALL have port byte_data  input  8  program byte, high byte of each word first.
REQ-008 SHALL have port byte_ready  output  1  loader accepts byte this cycle; transfer when byte_valid and byte_ready are both high.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  16  word address, with bits above ADDR_W-1 tied to 0.
REQ-011 SHALL have port mem_wdata  output  16  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  holds the processor off instruction fetch while loading.
REQ-013 SHALL have port done  output  1  level; load completed with the halt word written.
REQ-014 SHALL have port overflow_err  output  1  level; memory filled before the halt word arrived.
REQ-015 SHALL have port word_count  output  ADDR_W+1  number of words written in the current or last load.

Function
REQ-016 SHALL implement states IDLE, HI, LO, WRITE, DONE, ERR.
REQ-017 In IDLE, DONE or ERR, start SHALL move the loader to HI and clear mem_addr, word_count, done and overflow_err on the same edge.
REQ-018 SHALL assert byte_ready only in HI and LO, combinationally from state, independent of byte_valid.
REQ-019 HI: an accepted byte SHALL be latched as word[15:8], then go to LO; without a transfer the loader SHALL stay in HI indefinitely.
REQ-020 LO: an accepted byte SHALL form word {hi,byte}, then go to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with mem_we=1 and mem_wdata=word at the current mem_addr, and word_count SHALL increment at its end.
REQ-022 WRITE with word==HALT_WORD SHALL go to DONE; the halt word itself is written.
REQ-023 WRITE with mem_addr==2**ADDR_W-1 and word!=HALT_WORD SHALL go to ERR; mem_addr SHALL NOT wrap.
REQ-024 Otherwise WRITE SHALL increment mem_addr and return to HI.
REQ-025 Minimum throughput SHALL be one word per 3 cycles: HI, LO, WRITE.
REQ-026 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-027 cpu_hold SHALL be 1 in HI, LO, WRITE and ERR, and 0 in IDLE and DONE.
REQ-028 done SHALL be 1 only in DONE; overflow_err SHALL be 1 only in ERR.
REQ-029 start in HI, LO or WRITE SHALL be ignored, with no restart and no state change.
REQ-030 byte_valid outside HI and LO SHALL be ignored, and no byte is consumed.

Reset
REQ-031 reset SHALL have priority over start and over every transfer on the same edge.
REQ-032 reset SHALL force IDLE with mem_addr=0, word_count=0, latched byte=0, mem_we=0, byte_ready=0, cpu_hold=0, done=0 and overflow_err=0.
REQ-033 reset mid-load SHALL abandon the partial word, and no write SHALL occur on or after the reset edge.

Structure
REQ-034 State encoding, HALT_WORD and the default ADDR_W SHALL live in the shared processor package alongside the other ISA constants.
REQ-035 SHALL be a single module with no sub-modules; the byte-to-word assembler is inline.
REQ-036 SHALL connect to the write port of a writable instruction memory; the read port stays with instruction fetch.

Verification
REQ-037 Program load: start, then stream bytes 20 09 20 0A 01 2A 01 2B 01 4B 01 4B 01 6A 01 8B FF FF with continuous byte_valid. Required: 9 writes at addresses 0..8, data 2009,200A,012A,012B,014B,014B,016A,018B,FFFF; done=1; word_count=9; cpu_hold 1->0; writes 3 cycles apart.
REQ-038 Backpressure: toggle byte_valid randomly during the same stream. Required: identical write sequence and no duplicate or lost bytes.
REQ-039 Overflow with ADDR_W=2: stream 4 non-halt words 1111,2222,3333,4444. Required: writes at 0..3; overflow_err=1; word_count=4; cpu_hold stays 1; no write to address 4.
REQ-040 Ignored start: pulse start after word 2 of a 5-word program ending in FFFF. Required: addresses continue 2,3,4 with no restart, and done=1.
REQ-041 Reset mid-word: assert reset after high byte 12 is accepted. Required: IDLE with all outputs 0; a following start plus 12 34 FF FF writes 1234@0 and FFFF@1.
REQ-042 Restart after DONE: start again. Required: done cleared on that edge, mem_addr=0, and the new program overwrites from address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared processor constants and loader state encoding
package imem_loader_pkg;

    localparam int          IMEM_ADDR_W    = 10;
    localparam logic [15:0] IMEM_HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory program loader
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = IMEM_ADDR_W,
    parameter logic [15:0] HALT_WORD = IMEM_HALT_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    loader_state_t     state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W:0]   count_q, count_n;
    logic [7:0]        hi_q, hi_n;
    logic [15:0]       word_q, word_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            hi_q    <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            count_q <= count_n;
            hi_q    <= hi_n;
            word_q  <= word_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        addr_n       = addr_q;
        count_n      = count_q;
        hi_n         = hi_q;
        word_n       = word_q;
        byte_ready   = 1'b0;
        mem_we       = 1'b0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        overflow_err = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                done         = (state_q == DONE);
                overflow_err = (state_q == ERR);
                cpu_hold     = (state_q == ERR);
                if (start) begin
                    state_n = HI;
                    addr_n  = '0;
                    count_n = '0;
                end
            end
            HI: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    hi_n    = byte_data;
                    state_n = LO;
                end
            end
            LO: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    word_n  = {hi_q, byte_data};
                    state_n = WRITE;
                end
            end
            WRITE: begin
                mem_we   = 1'b1;
                cpu_hold = 1'b1;
                count_n  = count_q + (ADDR_W+1)'(1);
                // The halt word wins even at the last address: it still fits.
                if (word_q == HALT_WORD) begin
                    state_n = DONE;
                end else if (addr_q == LAST_ADDR) begin
                    state_n = ERR;
                end else begin
                    addr_n  = addr_q + ADDR_W'(1);
                    state_n = HI;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr   = 16'(addr_q);
    assign mem_wdata  = word_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_b = 1'b0, valid_b = 1'b0;
    logic [7:0]  data_b = 8'h00;
    logic        ready_b, we_b, hold_b, done_b, err_b;
    logic [15:0] addr_b, wdata_b;
    logic [10:0] count_b;
    logic        start_s = 1'b0, valid_s = 1'b0;
    logic [7:0]  data_s = 8'h00;
    logic        ready_s, we_s, hold_s, done_s, err_s;
    logic [15:0] addr_s, wdata_s;
    logic [2:0]  count_s;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    wr_t         mon_b[$];
    wr_t         mon_s[$];
    logic [7:0]  prog[$];
    logic [15:0] exp_d[$];
    bit          exp_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader dut_big (
        .clk(clk), .reset(reset), .start(start_b), .byte_valid(valid_b),
        .byte_data(data_b), .byte_ready(ready_b), .mem_we(we_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .cpu_hold(hold_b),
        .done(done_b), .overflow_err(err_b), .word_count(count_b)
    );

    imem_loader #(.ADDR_W(2)) dut_small (
        .clk(clk), .reset(reset), .start(start_s), .byte_valid(valid_s),
        .byte_data(data_s), .byte_ready(ready_s), .mem_we(we_s),
        .mem_addr(addr_s), .mem_wdata(wdata_s), .cpu_hold(hold_s),
        .done(done_s), .overflow_err(err_s), .word_count(count_s)
    );

    always @(negedge clk) begin
        if (we_b) mon_b.push_back('{addr_b, wdata_b, cyc});
        if (we_s) mon_s.push_back('{addr_s, wdata_s, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input bit sel); return sel ? ready_s : ready_b; endfunction
    function automatic logic get_done(input bit sel);  return sel ? done_s  : done_b;  endfunction
    function automatic logic get_err(input bit sel);   return sel ? err_s   : err_b;   endfunction
    function automatic logic get_hold(input bit sel);  return sel ? hold_s  : hold_b;  endfunction
    function automatic logic get_we(input bit sel);    return sel ? we_s    : we_b;    endfunction
    function automatic logic [31:0] get_count(input bit sel);
        return sel ? 32'(count_s) : 32'(count_b);
    endfunction
    function automatic logic [31:0] get_addr(input bit sel);
        return sel ? 32'(addr_s) : 32'(addr_b);
    endfunction
    function automatic int mon_size(input bit sel);
        return sel ? mon_s.size() : mon_b.size();
    endfunction
    function automatic wr_t mon_get(input bit sel, input int k);
        return sel ? mon_s[k] : mon_b[k];
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_s = v; else start_b = v;
    endtask

    task automatic set_byte(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin valid_s = v; data_s = d; end
        else begin valid_b = v; data_b = d; end
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
    endtask

    // Reference: consecutive byte pairs form words; load stops on the halt
    // word (done) or once the memory depth has been filled (overflow).
    task automatic build_expect(input int depth);
        logic [15:0] w;
        exp_d.delete();
        exp_done = 1'b0;
        for (int k = 0; k < prog.size() / 2; k++) begin
            w = {prog[2*k], prog[2*k+1]};
            exp_d.push_back(w);
            if (w == 16'hFFFF) begin
                exp_done = 1'b1;
                break;
            end
            if (k == depth - 1) break;
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        prog.push_back(w[15:8]);
        prog.push_back(w[7:0]);
    endtask

    task automatic stream(input bit sel, input bit rnd);
        int  i = 0;
        int  budget = 0;
        logic v;
        while (i < prog.size() && budget < 4000) begin
            @(negedge clk);
            if (get_done(sel) || get_err(sel)) break;
            v = rnd ? logic'($urandom_range(0, 2) != 0) : 1'b1;
            set_byte(sel, v, prog[i]);
            if (v && get_ready(sel)) i++;
            budget++;
        end
        check("stream_budget", 32'(budget < 4000), 32'd1);
        @(negedge clk);
        set_byte(sel, 1'b0, 8'h00);
    endtask

    task automatic wait_end(input bit sel);
        int n = 0;
        while (!(get_done(sel) || get_err(sel)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("end_timeout", 32'(get_done(sel) || get_err(sel)), 32'd1);
    endtask

    task automatic run_load(input bit sel, input bit rnd, input bit spacing);
        wr_t w;
        if (sel) mon_s.delete(); else mon_b.delete();
        pulse_start(sel);
        check("start_done_clr", 32'(get_done(sel)), 32'd0);
        check("start_err_clr", 32'(get_err(sel)), 32'd0);
        check("start_count_clr", get_count(sel), 32'd0);
        check("start_ready", 32'(get_ready(sel)), 32'd1);
        check("start_hold", 32'(get_hold(sel)), 32'd1);
        stream(sel, rnd);
        wait_end(sel);
        @(negedge clk);
        check("n_writes", 32'(mon_size(sel)), 32'(exp_d.size()));
        for (int k = 0; k < mon_size(sel) && k < exp_d.size(); k++) begin
            w = mon_get(sel, k);
            check($sformatf("wr_addr[%0d]", k), 32'(w.addr), 32'(k));
            check($sformatf("wr_data[%0d]", k), 32'(w.data), 32'(exp_d[k]));
            if (spacing && k > 0)
                check($sformatf("wr_gap[%0d]", k), 32'(w.cyc - mon_get(sel, k-1).cyc), 32'd3);
        end
        check("done", 32'(get_done(sel)), 32'(exp_done));
        check("overflow_err", 32'(get_err(sel)), 32'(!exp_done));
        check("word_count", get_count(sel), 32'(exp_d.size()));
        check("cpu_hold_end", 32'(get_hold(sel)), 32'(!exp_done));
        check("ready_end", 32'(get_ready(sel)), 32'd0);
    endtask

    task automatic check_idle(input bit sel, input string pfx);
        check({pfx, "_ready"}, 32'(get_ready(sel)), 32'd0);
        check({pfx, "_we"},    32'(get_we(sel)),    32'd0);
        check({pfx, "_hold"},  32'(get_hold(sel)),  32'd0);
        check({pfx, "_done"},  32'(get_done(sel)),  32'd0);
        check({pfx, "_err"},   32'(get_err(sel)),   32'd0);
        check({pfx, "_count"}, get_count(sel),      32'd0);
        check({pfx, "_addr"},  get_addr(sel),       32'd0);
    endtask

    initial begin
        logic [7:0]  req_bytes [18];
        logic [15:0] w;
        int          nw;
        bit          pulsed;

        req_bytes = '{8'h20, 8'h09, 8'h20, 8'h0A, 8'h01, 8'h2A, 8'h01, 8'h2B, 8'h01,
                      8'h4B, 8'h01, 8'h4B, 8'h01, 8'h6A, 8'h01, 8'h8B, 8'hFF, 8'hFF};

        repeat (3) @(negedge clk);
        check_idle(1'b0, "rst_big");
        check_idle(1'b1, "rst_small");
        check("rst_wdata", 32'(wdata_b), 32'd0);
        reset = 1'b0;

        // Reference program, continuous stream, 3-cycle write spacing.
        prog.delete();
        foreach (req_bytes[i]) prog.push_back(req_bytes[i]);
        build_expect(1024);
        run_load(1'b0, 1'b0, 1'b1);

        // Same program again under random backpressure; also a restart after DONE.
        run_load(1'b0, 1'b1, 1'b0);

        for (int it = 0; it < 4; it++) begin
            prog.delete();
            nw = $urandom_range(1, 12);
            for (int k = 0; k < nw; k++) push_word(16'($urandom_range(0, 16'hFFFE)));
            push_word(16'hFFFF);
            build_expect(1024);
            run_load(1'b0, 1'b1, 1'b0);
        end

        // Start pulsed mid-load must be ignored.
        prog.delete();
        for (int k = 0; k < 4; k++) push_word(16'($urandom_range(0, 16'hFFFE)));
        push_word(16'hFFFF);
        build_expect(1024);
        mon_b.delete();
        pulsed = 1'b0;
        fork
            run_load(1'b0, 1'b1, 1'b0);
            begin
                for (int n = 0; n < 300 && !pulsed; n++) begin
                    @(negedge clk);
                    if (mon_b.size() >= 2) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        pulse_start(1'b0);
                        pulsed = 1'b1;
                    end
                end
            end
        join
        check("mid_start_pulsed", 32'(pulsed), 32'd1);

        // Overflow on the 4-word memory.
        prog.delete();
        push_word(16'h1111); push_word(16'h2222); push_word(16'h3333); push_word(16'h4444);
        build_expect(4);
        run_load(1'b1, 1'b0, 1'b0);
        repeat (6) begin
            @(negedge clk);
            set_byte(1'b1, 1'b1, 8'h55);
        end
        @(negedge clk);
        set_byte(1'b1, 1'b0, 8'h00);
        check("ovf_no_more_writes", 32'(mon_s.size()), 32'd4);
        check("ovf_hold_stays", 32'(hold_s), 32'd1);
        check("ovf_err_stays", 32'(err_s), 32'd1);

        // Random programs against the small memory: mix of halt and overflow.
        for (int it = 0; it < 6; it++) begin
            prog.delete();
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                w = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
                push_word(w);
            end
            push_word(16'hFFFF);
            build_expect(4);
            run_load(1'b1, 1'b1, 1'b0);
        end

        // Reset after the high byte: partial word dropped, no write.
        mon_b.delete();
        pulse_start(1'b0);
        set_byte(1'b0, 1'b1, 8'h12);
        @(negedge clk);
        reset = 1'b1;
        set_byte(1'b0, 1'b1, 8'h34);
        set_start(1'b0, 1'b1);
        @(negedge clk);
        check_idle(1'b0, "midrst");
        check("midrst_wdata", 32'(wdata_b), 32'd0);
        reset = 1'b0;
        set_start(1'b0, 1'b0);
        set_byte(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("midrst_no_write", 32'(mon_b.size()), 32'd0);
        check_idle(1'b0, "midrst_after");
        prog.delete();
        push_word(16'h1234);
        push_word(16'hFFFF);
        build_expect(1024);
        run_load(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
